rx_skid_sink: RTL and testbench

- 32-bit valid/ready receive endpoint; consumer side of a tx→rx link.
- The transmitter samples `ready` through one register stage, so it may still send words for up to SKID cycles after `ready` falls. The sink therefore accepts every valid word into a small FIFO with skid headroom.
- Words drain at a programmable rate onto the registered `data_show` output, for display and debug.

---
 rtl/rx_pkg.sv | 16 +
 rtl/rx_sync_fifo.sv | 46 ++++
 rtl/rx_skid_sink.sv | 91 +++++++++
 tb/tb_rx_skid_sink.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the rx_skid_sink receive endpoint: payload width,
// pointer-width helper and payload type.
package rx_pkg;

  localparam int DATA_W    = 32;
  localparam int DEPTH_DEF = 8;
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

  typedef logic [DATA_W-1:0] data_t;

  // Address bits needed for a power-of-two FIFO; the caller adds the wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rx_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push and a pop in the same cycle
// are both performed, so a full FIFO can accept a word while it pops.
module rx_sync_fifo #(
  parameter int DATA_W = rx_pkg::DATA_W,
  parameter int DEPTH  = rx_pkg::DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [rx_pkg::ptr_w(DEPTH):0] count
);
  import rx_pkg::*;

  localparam int AW = ptr_w(DEPTH);

  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Pointer update; reset flushes all stored words
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage write; the head is read before this edge, so push-on-pop at full is safe
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
  end

  assign pop_data = mem_r[rd_ptr_r[AW-1:0]];
  assign full     = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign count    = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/rx_skid_sink.sv
// Ready-latency tolerant receive sink with skid FIFO and rate-limited drain.
// Optional RX_SKID_SINK_STATS_EN adds rx_count / drop_count outputs.
module rx_skid_sink #(
  parameter int DATA_W    = rx_pkg::DATA_W,
  parameter int DEPTH     = 8,
  parameter int SKID      = 2,
  parameter int DRAIN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic [DATA_W-1:0] data_show,
  output logic              overflow
`ifdef RX_SKID_SINK_STATS_EN
  ,
  output logic [15:0]       rx_count,
  output logic [7:0]        drop_count
`endif
);
  import rx_pkg::*;

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic [AW:0]       count_s;
  logic [AW:0]       count_next_s;
  logic [AW:0]       free_next_s;
  logic [DATA_W-1:0] head_s;
  logic [CW-1:0]     div_r;

  rx_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (data),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Push/pop decisions and next-cycle free space; ready does not gate the write
  always_comb begin
    pop_s        = !empty_s && (div_r == CW'(DRAIN_DIV - 1));
    push_s       = valid && (!full_s || pop_s);
    drop_s       = valid && !push_s;
    count_next_s = count_s + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    free_next_s  = (AW+1)'(DEPTH) - count_next_s;
  end

  // Ready, drain divider, display register and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      ready     <= 1'b0;
      div_r     <= {CW{1'b0}};
      data_show <= {DATA_W{1'b0}};
      overflow  <= 1'b0;
    end else begin
      ready <= (free_next_s > (AW+1)'(SKID));
      if (empty_s || (div_r == CW'(DRAIN_DIV - 1))) begin
        div_r <= {CW{1'b0}};
      end else begin
        div_r <= div_r + CW'(1);
      end
      if (pop_s)  data_show <= head_s;
      if (drop_s) overflow  <= 1'b1;
    end
  end

`ifdef RX_SKID_SINK_STATS_EN
  // Accepted count wraps, dropped count saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count   <= 16'd0;
      drop_count <= 8'd0;
    end else begin
      if (push_s) rx_count <= rx_count + 16'd1;
      if (drop_s && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_skid_sink.sv
// Self-checking bench for rx_skid_sink: directed scenarios with random payloads
// checked against a queue-based reference model.
module tb_rx_skid_sink;

  localparam int DEPTH     = 8;
  localparam int SKID      = 2;
  localparam int DRAIN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = 32'd0;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] data_show;
  logic        overflow;
`ifdef RX_SKID_SINK_STATS_EN
  logic [15:0] rx_count;
  logic [7:0]  drop_count;
`endif

  rx_skid_sink #(.DATA_W(32), .DEPTH(DEPTH), .SKID(SKID), .DRAIN_DIV(DRAIN_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .data_show  (data_show),
    .overflow   (overflow)
`ifdef RX_SKID_SINK_STATS_EN
    ,
    .rx_count   (rx_count),
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] q[$];
  int          ph = 0;
  logic [31:0] m_show = 32'd0;
  logic        m_ovf = 1'b0;
  logic        m_rdy = 1'b0;
  int          m_rx = 0;
  int          m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic tick(input logic v, input logic [31:0] d, input logic r);
    int sz;
    bit pop;
    bit acc;
    valid = v;
    data  = d;
    rst   = r;
    if (r) begin
      q.delete();
      ph = 0; m_show = 32'd0; m_ovf = 1'b0; m_rdy = 1'b0; m_rx = 0; m_drop = 0;
    end else begin
      sz  = q.size();
      pop = (sz > 0) && (ph == DRAIN_DIV - 1);
      acc = v && ((sz < DEPTH) || pop);
      if (pop) m_show = q.pop_front();
      if (acc) begin
        q.push_back(d);
        m_rx = (m_rx + 1) % 65536;
      end
      if (v && !acc) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      ph    = (sz == 0) ? 0 : (ph + 1) % DRAIN_DIV;
      m_rdy = (DEPTH - q.size()) > SKID;
    end
    @(posedge clk);
    #1;
    chk("ready", {31'd0, ready}, {31'd0, m_rdy});
    chk("data_show", data_show, m_show);
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef RX_SKID_SINK_STATS_EN
    chk("rx_count", {16'd0, rx_count}, 32'(m_rx));
    chk("drop_count", {24'd0, drop_count}, 32'(m_drop));
`endif
  endtask

  initial begin
    logic [31:0] w;
    logic        r1;
    logic        r2;
    logic        v;
    logic        saw_low;
    logic        saw_dead;
    int          n;

    // 1. Reset / startup
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'd0, 1'b1);
      chk("rst_ready_low", {31'd0, ready}, 32'd0);
    end
    tick(1'b0, 32'd0, 1'b0);
    chk("startup_ready", {31'd0, ready}, 32'd1);
    chk("startup_show", data_show, 32'd0);

    // 2. Single word appears on the 4th clock after acceptance
    tick(1'b1, 32'h0000_00A5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 32'd0, 1'b0);
      chk("single_early", data_show, 32'd0);
    end
    tick(1'b0, 32'd0, 1'b0);
    chk("single_show", data_show, 32'h0000_00A5);

    // 3. Burst with a transmitter that sees ready two cycles late
    r1 = 1'b1; r2 = 1'b1; n = 1; saw_low = 1'b0;
    for (int i = 0; i < 40; i++) begin
      v = r2;
      tick(v, v ? 32'(n) : 32'd0, 1'b0);
      if (v) n++;
      r2 = r1;
      r1 = ready;
      if (!ready) saw_low = 1'b1;
    end
    for (int i = 0; i < 40; i++) tick(1'b0, 32'd0, 1'b0);
    chk("burst_no_overflow", {31'd0, overflow}, 32'd0);
    chk("burst_ready_fell", {31'd0, saw_low}, 32'd1);

    // 4. Overflow while ignoring ready
    for (int i = 0; i < 12; i++) tick(1'b1, $urandom, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 40; i++) tick(1'b0, 32'd0, 1'b0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // 5. Push into a full FIFO on a pop cycle
    tick(1'b0, 32'd0, 1'b1);
    tick(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (q.size() < DEPTH) tick(1'b1, $urandom, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      if (ph != DRAIN_DIV - 1) tick(1'b0, 32'd0, 1'b0);
    end
    tick(1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("full_pop_no_ovf", {31'd0, overflow}, 32'd0);
    saw_dead = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 32'd0, 1'b0);
      if (data_show === 32'hDEAD_BEEF) saw_dead = 1'b1;
    end
    chk("full_pop_drained", {31'd0, saw_dead}, 32'd1);

    // 6. Mid-stream reset with words queued
    for (int i = 0; i < 6; i++) tick(1'b1, $urandom, 1'b0);
    tick(1'b1, $urandom, 1'b1);
    tick(1'b0, 32'd0, 1'b1);
    chk("flush_show", data_show, 32'd0);
    chk("flush_ovf", {31'd0, overflow}, 32'd0);
`ifdef RX_SKID_SINK_STATS_EN
    chk("flush_rx_count", {16'd0, rx_count}, 32'd0);
    chk("flush_drop_count", {24'd0, drop_count}, 32'd0);
`endif
    tick(1'b0, 32'd0, 1'b0);
    w = $urandom;
    tick(1'b1, w, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 32'd0, 1'b0);
    chk("post_flush_first", data_show, w);

    // Random traffic with occasional resets
    for (int i = 0; i < 250; i++) begin
      tick(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, $urandom,
           ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 40; i++) tick(1'b0, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
